jk_bank_driver: RTL and testbench

//  Controller that drives the j/k inputs of an external bank of W JK flip-flops (clk-only, no reset)
//  to a requested target word. Accepts targets over a valid/ready handshake and keeps a shadow copy
//  of the bank state. Limits how many bits change per cycle. Sits between a control/CPU side and a
//  JK register array: it produces j/k, the array produces q.

---
 rtl/jk_drv_pkg.sv | 27 ++
 rtl/jk_pick_lowest.sv | 24 ++
 rtl/jk_bank_driver.sv | 134 +++++++++++++
 tb/tb_jk_bank_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK bank driver.
// Build option: JK_DRV_VERIFY_EN enables the q_in vs shadow check.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRIVE
  } jk_drv_state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // {j,k} that moves one flop from cur to nxt
  function automatic logic [1:0] jk_excite(
    input logic cur,
    input logic nxt,
    input logic use_toggle
  );
    if (cur == nxt)
      return JK_HOLD;
    if (use_toggle)
      return JK_TOG;
    return {nxt, ~nxt};
  endfunction

endpackage

// File: rtl/jk_pick_lowest.sv
// Selects up to MAX_FLIPS lowest set bits of a pending-change mask.
// Build option: none.
module jk_pick_lowest #(
  parameter int W         = 8,
  parameter int MAX_FLIPS = 2
) (
  input  logic [W-1:0] rem,
  output logic [W-1:0] sel
);

  int cnt;

  always_comb begin
    sel = '0;
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (rem[i] && (cnt < MAX_FLIPS)) begin
        sel[i] = 1'b1;
        cnt    = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives j/k of an external JK flop bank towards accepted targets.
// Build option: JK_DRV_VERIFY_EN enables sticky q_in mismatch flag.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int W          = 8,
  parameter int MAX_FLIPS  = 2,
  parameter bit USE_TOGGLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_target,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  input  logic [W-1:0] q_in,
  output logic         busy,
  output logic         done,
  output logic         err
);

  jk_drv_state_t state_q, state_d;

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] sel;
  logic         done_q, done_d;
  logic         accept;

  jk_pick_lowest #(
    .W        (W),
    .MAX_FLIPS(MAX_FLIPS)
  ) u_pick (
    .rem(rem_q),
    .sel(sel)
  );

  assign accept = in_valid && in_ready;

  // Outputs depend on registered state only
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    j        = '0;
    k        = '0;
    unique case (state_q)
      ST_INIT: begin
        k = '1;
      end
      ST_DRIVE: begin
        for (int i = 0; i < W; i++) begin
          if (sel[i])
            {j[i], k[i]} = jk_excite(shadow_q[i], tgt_q[i], USE_TOGGLE);
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    rem_d    = rem_q;
    tgt_d    = tgt_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        shadow_d = '0;
        rem_d    = '0;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          tgt_d = in_target;
          rem_d = in_target ^ shadow_q;
          if (rem_d == '0)
            done_d = 1'b1;
          else
            state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        shadow_d = shadow_q ^ sel;
        rem_d    = rem_q & ~sel;
        if (rem_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      shadow_q <= '0;
      rem_q    <= '0;
      tgt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rem_q    <= rem_d;
      tgt_q    <= tgt_d;
      done_q   <= done_d;
    end
  end

`ifdef JK_DRV_VERIFY_EN
  logic err_q;

  // Bank and shadow update on the same edge, so they agree outside INIT
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state_q != ST_INIT) && (q_in != shadow_q))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_q;
  assign unused_q = ^q_in;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench: JK bank model, vector table, random targets.
// Build option: JK_DRV_VERIFY_EN adds the sticky err checks.
module tb_jk_bank_driver;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_target;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q_in;
  logic         busy;
  logic         done;
  logic         err;

  logic [W-1:0] bank_q;
  logic [W-1:0] flip;
  logic [W-1:0] mdl_q;

  int checks;
  int failures;

  jk_bank_driver #(
    .W         (W),
    .MAX_FLIPS (2),
    .USE_TOGGLE(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_target(in_target),
    .j        (j),
    .k        (k),
    .q_in     (q_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bank of plain JK flops
  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  assign q_in = bank_q ^ flip;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Lowest n set bits, peeled off with x & -x
  function automatic logic [W-1:0] low_bits(input logic [W-1:0] x,
                                            input int n);
    logic [W-1:0] r, b;
    r = '0;
    for (int c = 0; c < n; c++) begin
      b = x & (~x + 1'b1);
      r = r | b;
      x = x ^ b;
    end
    return r;
  endfunction

  function automatic int model_n(input logic [W-1:0] diff);
    return ($countones(diff) + 1) / 2;
  endfunction

  // Entered at a negedge with the DUT idle; leaves the same way
  task automatic do_txn(input logic [W-1:0] t, input int exp_n);
    logic [W-1:0] rem, sel;
    int cnt;
    rem = t ^ mdl_q;
    cnt = 0;
    chk("txn_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_target = t;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done)
        break;
      sel = low_bits(rem, 2);
      chk("drv_j", j, sel);
      chk("drv_k", k, sel);
      chk("drv_busy", busy, 1'b1);
      rem = rem ^ sel;
      cnt++;
      @(negedge clk);
    end
    chk("drv_cycles", cnt, exp_n);
    chk("done_pulse", done, 1'b1);
    chk("done_ready", in_ready, 1'b1);
    chk("done_jk", {j, k}, 16'h0000);
    chk("bank_q", bank_q, t);
    chk("err_clean", err, 1'b0);
    mdl_q = t;
    @(negedge clk);
    chk("done_drop", done, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] target;
    int           exp_n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_target = '0;
    flip      = '0;
    mdl_q     = '0;

    vecs[0] = '{8'h03, 1};
    vecs[1] = '{8'hF0, 3};
    vecs[2] = '{8'hF0, 0};
    vecs[3] = '{8'hFF, 2};
    vecs[4] = '{8'h00, 4};
    vecs[5] = '{8'h81, 1};

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_j", j, 8'h00);
    chk("init_k", k, 8'hFF);
    chk("init_ready", in_ready, 1'b0);
    chk("init_busy", busy, 1'b1);
    chk("init_done", done, 1'b0);
    chk("init_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_jk", {j, k}, 16'h0000);
    chk("idle_bank", bank_q, 8'h00);

    foreach (vecs[i])
      do_txn(vecs[i].target, vecs[i].exp_n);

    for (int r = 0; r < 30; r++) begin
      logic [W-1:0] t;
      t = W'($urandom);
      if (($urandom & 3) == 0)
        t = mdl_q;
      do_txn(t, model_n(t ^ mdl_q));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // offer held during DRIVE is not taken until IDLE
    do_txn(8'h00, model_n(mdl_q));
    in_valid  = 1'b1;
    in_target = 8'hFF;
    @(negedge clk);
    in_target = 8'h55;
    for (int c = 0; c < 4; c++) begin
      logic [W-1:0] s;
      s = 8'h03 << (2 * c);
      chk("hold_j", j, s);
      chk("hold_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    chk("hold_done", done, 1'b1);
    chk("hold_ready_idle", in_ready, 1'b1);
    chk("hold_bank_ff", bank_q, 8'hFF);
    @(negedge clk);
    chk("held_j0", j, 8'h0A);
    chk("held_busy", busy, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_j1", j, 8'hA0);
    @(negedge clk);
    chk("held_done", done, 1'b1);
    chk("held_bank", bank_q, 8'h55);
    mdl_q = 8'h55;
    @(negedge clk);

    // reset in the middle of DRIVE
    in_valid  = 1'b1;
    in_target = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    chk("mid_j", j, 8'h05);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_init_j", j, 8'h00);
    chk("mid_init_k", k, 8'hFF);
    chk("mid_init_ready", in_ready, 1'b0);
    chk("mid_init_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", in_ready, 1'b1);
    chk("mid_bank", bank_q, 8'h00);
    mdl_q = 8'h00;
    do_txn(8'h3C, 2);

`ifdef JK_DRV_VERIFY_EN
    flip = 8'h01;
    @(negedge clk);
    chk("err_set", err, 1'b1);
    flip = 8'h00;
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 1'b0);
`else
    flip = 8'h01;
    @(negedge clk);
    chk("err_tied", err, 1'b0);
    flip = 8'h00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
